// File: rtl/fixed_accumulator.sv
// Block accumulator for sign-magnitude fixed-point samples: sums len_i samples
// into a two's complement register, then holds the result until the consumer takes it.
module fixed_accumulator #(
    parameter int FRAC_W = 19,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              valid_i,
    input  logic              sign_i,
    input  logic              integer_i,
    input  logic [FRAC_W-1:0] fractional_i,
    output logic              busy_o,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic              ovf_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [ACC_W-1:0]   acc_d, mag, operand, total;
    logic               ovf_d, ovf_add;

    // Negating a zero magnitude gives zero, so negative zero needs no special case.
    assign mag      = {{(ACC_W-FRAC_W-1){1'b0}}, integer_i, fractional_i};
    assign operand  = sign_i ? (~mag + {{(ACC_W-1){1'b0}}, 1'b1}) : mag;
    assign total    = sum_o + operand;
    assign ovf_add  = (sum_o[ACC_W-1] == operand[ACC_W-1]) &&
                      (total[ACC_W-1] != sum_o[ACC_W-1]);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = sum_o;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_o;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        len_d   = len_i;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (valid_i) begin
                    acc_d = total;
                    cnt_d = cnt_inc;
                    if (ovf_add) ovf_d = 1'b1;
                    if (cnt_inc == len_q) state_d = DONE;
                end
            end
            DONE: begin
                if (sum_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with sum_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_o       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_o       <= 1'b0;
            busy_o      <= 1'b0;
            sum_valid_o <= 1'b0;
        end else begin
            sum_o       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_o       <= ovf_d;
            busy_o      <= (state_d != IDLE);
            sum_valid_o <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_fixed_accumulator.sv
// Scoreboarded bench: a 32-bit and a 22-bit accumulator share the stimulus;
// per-DUT monitors pop expected {ovf, sum} at each result handshake.
module tb_fixed_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [9:0]  len_i = '0;
    logic        valid_i = 1'b0;
    logic        sign_i = 1'b0;
    logic        integer_i = 1'b0;
    logic [18:0] fractional_i = '0;
    logic        sum_ready_i = 1'b0;

    logic        busy1, sum_valid1, ovf1;
    logic [31:0] sum1;
    logic        busy2, sum_valid2, ovf2;
    logic [21:0] sum2;

    int checks = 0;
    int errors = 0;

    logic [32:0] q1[$];
    logic [22:0] q2[$];

    always #5 clk = ~clk;

    fixed_accumulator #(.FRAC_W(19), .ACC_W(32), .CNT_W(10)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .valid_i(valid_i),
        .sign_i(sign_i), .integer_i(integer_i), .fractional_i(fractional_i),
        .busy_o(busy1), .sum_o(sum1), .sum_valid_o(sum_valid1),
        .sum_ready_i(sum_ready_i), .ovf_o(ovf1)
    );

    fixed_accumulator #(.FRAC_W(19), .ACC_W(22), .CNT_W(10)) dut2 (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .valid_i(valid_i),
        .sign_i(sign_i), .integer_i(integer_i), .fractional_i(fractional_i),
        .busy_o(busy2), .sum_o(sum2), .sum_valid_o(sum_valid2),
        .sum_ready_i(sum_ready_i), .ovf_o(ovf2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && sum_valid1 && sum_ready_i) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb1_unexpected: got %h, expected no result", {ovf1, sum1});
            end else begin
                chk("sb1_ovf_sum", {31'b0, ovf1, sum1}, {31'b0, q1.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && sum_valid2 && sum_ready_i) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb2_unexpected: got %h, expected no result", {ovf2, sum2});
            end else begin
                chk("sb2_ovf_sum", {41'b0, ovf2, sum2}, {41'b0, q2.pop_front()});
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [9:0] len, input logic push,
                               input logic [32:0] exp1, input logic [22:0] exp2);
        if (push) begin
            q1.push_back(exp1);
            q2.push_back(exp2);
        end
        start_i = 1'b1;
        len_i   = len;
        step();
        start_i = 1'b0;
    endtask

    task automatic sample(input logic s, input logic i, input logic [18:0] f, input int gap);
        valid_i      = 1'b1;
        sign_i       = s;
        integer_i    = i;
        fractional_i = f;
        step();
        valid_i = 1'b0;
        repeat (gap) step();
    endtask

    task automatic drain(input string tag);
        chk({tag, "_valid1"}, 64'(sum_valid1), 64'd1);
        chk({tag, "_valid2"}, 64'(sum_valid2), 64'd1);
        sum_ready_i = 1'b1;
        step();
        sum_ready_i = 1'b0;
        chk({tag, "_idle"}, {62'b0, busy1, sum_valid1}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, checked before any clock edge
        #2;
        chk("reset1", {sum1, 29'b0, busy1, sum_valid1, ovf1}, 64'd0);
        chk("reset2", {sum2, 39'b0, busy2, sum_valid2, ovf2}, 64'd0);
        step();
        rst = 1'b1;
        step();

        // four samples of 0.5 -> 2.0
        start_block(10'd4, 1'b1, {1'b0, 32'h0010_0000}, {1'b0, 22'h10_0000});
        chk("busy_accum", 64'(busy1), 64'd1);
        repeat (3) sample(1'b0, 1'b0, 19'h40000, 0);
        chk("no_early_valid", 64'(sum_valid1), 64'd0);
        sample(1'b0, 1'b0, 19'h40000, 0);
        chk("sum_2p0", 64'(sum1), 64'h0010_0000);
        drain("blk_half");

        // +1.0, -0.25, negative zero with gaps -> 0.75
        start_block(10'd3, 1'b1, {1'b0, 32'h0006_0000}, {1'b0, 22'h06_0000});
        sample(1'b0, 1'b1, 19'h00000, 2);
        sample(1'b1, 1'b0, 19'h20000, 2);
        chk("no_valid_before_last", 64'(sum_valid1), 64'd0);
        sample(1'b1, 1'b0, 19'h00000, 0);
        drain("blk_mixed");

        // empty block held off by the consumer
        start_block(10'd0, 1'b1, 33'd0, 23'd0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_sum", 64'(sum1), 64'd0);
            chk("stall_valid", {62'b0, sum_valid1, busy1}, 64'd3);
            step();
        end
        drain("blk_empty");

        // three near-2.0 samples overflow the 22-bit accumulator only
        start_block(10'd3, 1'b1, {1'b0, 32'h002F_FFFD}, {1'b1, 22'h2F_FFFD});
        repeat (3) sample(1'b0, 1'b1, 19'h7FFFF, 0);
        chk("ovf22_set", 64'(ovf2), 64'd1);
        chk("ovf32_clear", 64'(ovf1), 64'd0);
        drain("blk_ovf");
        start_block(10'd1, 1'b1, {1'b0, 32'h0004_0000}, {1'b0, 22'h04_0000});
        chk("ovf22_cleared", 64'(ovf2), 64'd0);
        sample(1'b0, 1'b0, 19'h40000, 0);
        drain("blk_after_ovf");

        // reset mid-block discards the partial sum
        start_block(10'd4, 1'b0, 33'd0, 23'd0);
        repeat (2) sample(1'b0, 1'b1, 19'h00000, 0);
        rst = 1'b0;
        #2;
        chk("async_rst1", {sum1, 29'b0, busy1, sum_valid1, ovf1}, 64'd0);
        chk("async_rst2", {sum2, 39'b0, busy2, sum_valid2, ovf2}, 64'd0);
        step();
        step();
        rst = 1'b1;
        repeat (3) sample(1'b0, 1'b1, 19'h00000, 0);
        chk("ignore_valid_idle", {sum1, 30'b0, busy1, sum_valid1}, 64'd0);
        start_block(10'd4, 1'b1, {1'b0, 32'h0008_0000}, {1'b0, 22'h08_0000});
        repeat (4) sample(1'b0, 1'b0, 19'h20000, 0);
        drain("blk_post_rst");

        // start held high through accumulation and handshake
        q1.push_back({1'b0, 32'h0006_0000});
        q2.push_back({1'b0, 22'h06_0000});
        start_i = 1'b1;
        len_i   = 10'd2;
        step();
        sample(1'b0, 1'b0, 19'h40000, 0);
        chk("no_restart_accum", 64'(sum1), 64'h0004_0000);
        sample(1'b0, 1'b0, 19'h20000, 0);
        drain("blk_start_held");
        start_i = 1'b0;
        chk("busy_after_held", 64'(busy2), 64'd0);
        step();

        chk("sb1_drained", 64'(q1.size()), 64'd0);
        chk("sb2_drained", 64'(q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_accumulator.md
FIXED_ACCUMULATOR -- requirements
Module: fixed_accumulator

Interface
REQ-001 The module SHALL have parameter FRAC_W, default 19, meaning fractional bits of input and sum.
REQ-002 The module SHALL have parameter ACC_W, default 32, meaning accumulator/sum width (two's complement, FRAC_W fractional bits).
REQ-003 The module SHALL have parameter CNT_W, default 10, meaning width of block-length and sample counter.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have port start_i  input  1  begin a new accumulation block.
REQ-007 The module SHALL have port len_i  input  CNT_W  samples per block, sampled with start_i.
REQ-008 The module SHALL have port valid_i  input  1  sample present on sign_i/integer_i/fractional_i.
REQ-009 The module SHALL have port sign_i  input  1  sample sign (1 = negative), sign-magnitude as produced by the cordic stage.
REQ-010 The module SHALL have port integer_i  input  1  sample integer bit.
REQ-011 The module SHALL have port fractional_i  input  FRAC_W  sample fractional bits.
REQ-012 The module SHALL have port busy_o  output  1  high in ACCUM and DONE.
REQ-013 The module SHALL have port sum_o  output  ACC_W  block sum, two's complement.
REQ-014 The module SHALL have port sum_valid_o  output  1  sum_o holds a completed block result.
REQ-015 The module SHALL have port sum_ready_i  input  1  consumer accepts sum_o.
REQ-016 The module SHALL have port ovf_o  output  1  sticky signed-overflow flag for current block.

Function
REQ-017 The operand SHALL be magnitude {integer_i, fractional_i} (FRAC_W+1 bits) zero-extended to ACC_W, negated (two's complement) when sign_i=1; negative zero SHALL yield 0.
REQ-018 The FSM SHALL have states IDLE, ACCUM, DONE; all outputs registered.
REQ-019 In IDLE with start_i=1 and len_i!=0: acc<=0, cnt<=0, len latched, ovf_o<=0, next ACCUM.
REQ-020 In IDLE with start_i=1 and len_i=0: acc<=0, ovf_o<=0, next DONE (empty block, sum 0).
REQ-021 In ACCUM each cycle with valid_i=1: acc<=acc+operand (mod 2^ACC_W), cnt<=cnt+1; cycles with valid_i=0 SHALL leave state unchanged.
REQ-022 At the edge accepting sample number len, state SHALL become DONE and sum_valid_o SHALL be 1 from that edge (one cycle after last valid_i cycle), sum_o = final total.
REQ-023 In DONE sum_o SHALL hold stable until sum_valid_o&&sum_ready_i; on that edge state SHALL become IDLE and sum_valid_o SHALL drop.
REQ-024 valid_i outside ACCUM SHALL be ignored; start_i outside IDLE SHALL be ignored, including start_i coincident with the DONE handshake.
REQ-025 ovf_o SHALL set when an addition overflows signed ACC_W (operands same sign, result sign differs), remain set until next accepted start, and be valid alongside sum_valid_o.
REQ-026 sum_o SHALL equal the accumulator register in all states.

Reset
REQ-027 While rst=0, immediately: state IDLE, acc=0, cnt=0, sum_o=0, sum_valid_o=0, busy_o=0, ovf_o=0, regardless of clock.
REQ-028 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial/held result; after release the block SHALL require a new start_i.

Verification
REQ-029 start_i, len_i=4; four valid_i samples sign=0, int=0, frac=0x40000 (0.5) -> sum_valid_o high one cycle after fourth sample, sum_o=0x00100000 (2.0), ovf_o=0.
REQ-030 len_i=3; samples +1.0 (int=1,frac=0), -0.25 (sign=1,frac=0x20000), negative zero (sign=1,int=0,frac=0), with valid_i gaps of 2 cycles -> sum_o=0x00060000 (0.75).
REQ-031 len_i=0 -> sum_valid_o high next cycle, sum_o=0; sum_ready_i held low 5 cycles -> sum_o and sum_valid_o stable; ready high -> IDLE next cycle, busy_o=0.
REQ-032 ACC_W=22, len_i=3, three samples int=1, frac=0x7FFFF -> ovf_o=1 with sum_valid_o; next start clears ovf_o.
REQ-033 rst pulsed low after 2 of 4 samples -> all outputs 0 asynchronously; subsequent valid_i without start_i ignored; new 4-sample block sums correctly from 0.
REQ-034 start_i held high during ACCUM and at DONE handshake -> no restart; state returns to IDLE and busy_o=0.
